// File: rtl/prod_stutter_ctrl.sv
// ============================================================================
// Module   : prod_stutter_ctrl
// Brief    : Lockstep stutter scheduler for a Left/Right self-composed product
//            circuit. Optional stutter timeout: PROD_STUTTER_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module prod_stutter_ctrl #(
    parameter int OBS_W       = 32,
    parameter int INIT_CYCLES = 2,
    parameter int CNT_W       = 16,
    parameter int MAX_STUTTER = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             retire_l_i,
    input  logic             retire_r_i,
    input  logic [OBS_W-1:0] obs_l_i,
    input  logic [OBS_W-1:0] obs_r_i,
    input  logic             halt_l_i,
    input  logic             halt_r_i,
    output logic             init_o,
    output logic             stall_l_o,
    output logic             stall_r_o,
    output logic [CNT_W-1:0] pairs_o,
    output logic             done_o,
    output logic             violation_o,
    output logic             timeout_o
);

    localparam int INIT_W = $clog2(INIT_CYCLES + 1);
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_RUN    = 3'd1,
        S_WAIT_L = 3'd2,
        S_WAIT_R = 3'd3,
        S_DONE   = 3'd4,
        S_VIOL   = 3'd5
    } state_t;

    state_t            state, state_nxt;
    logic [INIT_W-1:0] init_cnt, init_cnt_nxt;
    logic [OBS_W-1:0]  latch, latch_nxt;
    logic              pair_inc;

`ifdef PROD_STUTTER_TIMEOUT_EN
    localparam int STUT_W = $clog2(MAX_STUTTER + 1);
    logic [STUT_W-1:0] stut_cnt;
    logic              stut_expired;
    logic              timeout_set;
    logic              timeout_q;

    assign stut_expired = (stut_cnt == STUT_W'(MAX_STUTTER - 1));
`endif

    always_comb begin
        state_nxt    = state;
        init_cnt_nxt = init_cnt;
        latch_nxt    = latch;
        pair_inc     = 1'b0;
`ifdef PROD_STUTTER_TIMEOUT_EN
        timeout_set  = 1'b0;
`endif
        case (state)
            S_INIT: begin
                if (init_cnt == INIT_LAST) state_nxt = S_RUN;
                else                       init_cnt_nxt = init_cnt + 1'b1;
            end
            S_RUN: begin
                // A retirement always wins over a halt seen in the same cycle.
                if (retire_l_i && retire_r_i) begin
                    if (obs_l_i == obs_r_i) pair_inc  = 1'b1;
                    else                    state_nxt = S_VIOL;
                end else if (retire_l_i) begin
                    latch_nxt = obs_l_i;
                    state_nxt = S_WAIT_R;
                end else if (retire_r_i) begin
                    latch_nxt = obs_r_i;
                    state_nxt = S_WAIT_L;
                end else if (halt_l_i && halt_r_i) begin
                    state_nxt = S_DONE;
                end
            end
            S_WAIT_R: begin
                if (retire_r_i) begin
                    if (latch == obs_r_i) begin
                        pair_inc  = 1'b1;
                        state_nxt = S_RUN;
                    end else begin
                        state_nxt = S_VIOL;
                    end
                end else if (halt_r_i) begin
                    state_nxt = S_VIOL;
                end
`ifdef PROD_STUTTER_TIMEOUT_EN
                else if (stut_expired) begin
                    state_nxt   = S_VIOL;
                    timeout_set = 1'b1;
                end
`endif
            end
            S_WAIT_L: begin
                if (retire_l_i) begin
                    if (latch == obs_l_i) begin
                        pair_inc  = 1'b1;
                        state_nxt = S_RUN;
                    end else begin
                        state_nxt = S_VIOL;
                    end
                end else if (halt_l_i) begin
                    state_nxt = S_VIOL;
                end
`ifdef PROD_STUTTER_TIMEOUT_EN
                else if (stut_expired) begin
                    state_nxt   = S_VIOL;
                    timeout_set = 1'b1;
                end
`endif
            end
            S_DONE:  state_nxt = S_DONE;
            S_VIOL:  state_nxt = S_VIOL;
            default: state_nxt = S_VIOL;
        endcase
    end

    // Outputs are flopped from the next state so they line up with it.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state       <= S_INIT;
            init_cnt    <= '0;
            latch       <= '0;
            pairs_o     <= '0;
            init_o      <= 1'b1;
            stall_l_o   <= 1'b1;
            stall_r_o   <= 1'b1;
            done_o      <= 1'b0;
            violation_o <= 1'b0;
        end else begin
            state       <= state_nxt;
            init_cnt    <= init_cnt_nxt;
            latch       <= latch_nxt;
            if (pair_inc && (pairs_o != {CNT_W{1'b1}})) pairs_o <= pairs_o + 1'b1;
            init_o      <= (state_nxt == S_INIT);
            stall_l_o   <= (state_nxt == S_INIT) || (state_nxt == S_WAIT_R) ||
                           (state_nxt == S_DONE) || (state_nxt == S_VIOL);
            stall_r_o   <= (state_nxt == S_INIT) || (state_nxt == S_WAIT_L) ||
                           (state_nxt == S_DONE) || (state_nxt == S_VIOL);
            done_o      <= (state_nxt == S_DONE);
            violation_o <= (state_nxt == S_VIOL);
        end
    end

`ifdef PROD_STUTTER_TIMEOUT_EN
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stut_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state == S_RUN) stut_cnt <= '0;
            else if ((state == S_WAIT_L) || (state == S_WAIT_R)) stut_cnt <= stut_cnt + 1'b1;
            if (timeout_set) timeout_q <= 1'b1;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule

`default_nettype wire
